// File: rtl/max_three_ctrl.sv
// max_three_ctrl: unsigned max of three operands behind an ap_* handshake.
// Ports: ap_clk/ap_rst_n, ap_start/ap_ready/ap_done/ap_idle, a/b/c in, ap_return, ops_cnt.
module max_three_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] ap_return,
  output logic [CNT_W-1:0]  ops_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CMP1,
    CMP2,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              idle_q, idle_d;

  logic              accept;
  logic [DATA_W-1:0] cmp_x;
  logic [DATA_W-1:0] cmp_y;
  logic [DATA_W-1:0] cmp_max;

  // ap_ready is forced low while reset is held.
  always_comb begin
    accept = (state_q == IDLE) && ap_start && ap_rst_n;
  end

  // One comparator, operands steered by the current compare state.
  always_comb begin
    cmp_x   = (state_q == CMP2) ? m_q : a_q;
    cmp_y   = (state_q == CMP2) ? c_q : b_q;
    cmp_max = (cmp_x > cmp_y) ? cmp_x : cmp_y;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    m_d     = m_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          c_d     = c;
          state_d = CMP1;
        end
      end
      CMP1: begin
        m_d     = cmp_max;
        state_d = CMP2;
      end
      CMP2: begin
        res_d   = cmp_max;
        state_d = DONE;
      end
      DONE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      m_q     <= m_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    ap_ready  = accept;
    ap_done   = done_q;
    ap_idle   = idle_q;
    ap_return = res_q;
    ops_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_max_three_ctrl.sv
// tb_max_three_ctrl: randomized self-checking bench for max_three_ctrl.
// Two instances share stimulus: default widths and CNT_W=4 for wrap.
module tb_max_three_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] c = '0;

  logic        ready, done, idle;
  logic [31:0] ret;
  logic [15:0] cnt;
  logic        ready4, done4, idle4;
  logic [31:0] ret4;
  logic [3:0]  cnt4;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_cnt = '0;
  logic [3:0]  m_cnt4 = '0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  max_three_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start),
    .ap_ready(ready), .ap_done(done), .ap_idle(idle),
    .a(a), .b(b), .c(c), .ap_return(ret), .ops_cnt(cnt)
  );

  max_three_ctrl #(.DATA_W(32), .CNT_W(4)) dut4 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start),
    .ap_ready(ready4), .ap_done(done4), .ap_idle(idle4),
    .a(a), .b(b), .c(c), .ap_return(ret4), .ops_cnt(cnt4)
  );

  function automatic logic [31:0] ref_max(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] z);
    logic [31:0] v[3];
    logic [31:0] r;
    v[0] = x; v[1] = y; v[2] = z;
    r = '0;
    foreach (v[i]) if (v[i] > r) r = v[i];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a = $urandom; b = $urandom; c = $urandom;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || done !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL rst_ctrl got rdy=%b done=%b idle=%b exp 0 0 1",
               ready, done, idle);
    end
    checks++;
    if (ret !== 32'd0 || cnt !== 16'd0 || cnt4 !== 4'd0) begin
      errors++;
      $display("FAIL rst_data got ret=%h cnt=%0d cnt4=%0d exp 0 0 0",
               ret, cnt, cnt4);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    m_cnt = '0;
    m_cnt4 = '0;
    last_res = '0;
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input string tag);
    logic [31:0] exp;
    exp = ref_max(x, y, z);
    @(negedge clk);
    a = x; b = y; c = z; start = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || idle !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept got rdy=%b idle=%b exp 1 1", tag, ready, idle);
    end
    // CMP1: start kept high and operands scrambled; neither may matter.
    @(negedge clk);
    a = $urandom; b = $urandom; c = $urandom;
    #1;
    checks++;
    if (ready !== 1'b0 || idle !== 1'b0 || done !== 1'b0 ||
        ret !== last_res) begin
      errors++;
      $display("FAIL %s_cmp1 got rdy=%b idle=%b done=%b ret=%h exp 0 0 0 %h",
               tag, ready, idle, done, ret, last_res);
    end
    @(negedge clk);
    a = $urandom; b = $urandom; c = $urandom;
    #1;
    checks++;
    if (ready !== 1'b0 || idle !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_cmp2 got rdy=%b idle=%b done=%b exp 0 0 0",
               tag, ready, idle, done);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || done4 !== 1'b1 || ret !== exp || idle !== 1'b0 ||
        ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got done=%b done4=%b ret=%h idle=%b exp 1 1 %h 0",
               tag, done, done4, ret, idle, exp);
    end
    last_res = exp;
    m_cnt = m_cnt + 16'd1;
    m_cnt4 = m_cnt4 + 4'd1;
    @(negedge clk);
    #1;
    checks++;
    if (idle !== 1'b1 || done !== 1'b0 || ret !== exp ||
        cnt !== m_cnt || cnt4 !== m_cnt4) begin
      errors++;
      $display("FAIL %s_after got idle=%b done=%b ret=%h cnt=%0d cnt4=%0d exp 1 0 %h %0d %0d",
               tag, idle, done, ret, cnt, cnt4, exp, m_cnt, m_cnt4);
    end
  endtask

  task automatic test_basic();
    run_op(32'd5, 32'd9, 32'd3, "basic");
  endtask

  task automatic test_boundary();
    run_op(32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "unsigned");
    run_op(32'h1234, 32'h1234, 32'h1234, "equal");
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0001, "msb");
  endtask

  task automatic test_hold();
    run_op(32'd1, 32'd2, 32'd3, "hold");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [31:0] x, y, z;
      x = $urandom; y = $urandom; z = $urandom;
      if (i % 5 == 0) y = x;
      run_op(x, y, z, "rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops[12];
    int n_rdy, n_done;
    n_rdy = 0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = 1'b1;
      a = $urandom; b = $urandom; c = $urandom;
      ops[i] = ref_max(a, b, c);
      #1;
      if (ready === 1'b1) n_rdy++;
      if (done === 1'b1) n_done++;
      checks++;
      if (ready !== (i % 4 == 0) || idle !== (i % 4 == 0) ||
          done !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL b2b_ctrl cyc=%0d got rdy=%b idle=%b done=%b exp %b %b %b",
                 i, ready, idle, done, i % 4 == 0, i % 4 == 0, i % 4 == 3);
      end
      if (i % 4 == 3) begin
        checks++;
        if (ret !== ops[i-3]) begin
          errors++;
          $display("FAIL b2b_ret cyc=%0d got %h exp %h", i, ret, ops[i-3]);
        end
        last_res = ops[i-3];
        m_cnt = m_cnt + 16'd1;
        m_cnt4 = m_cnt4 + 4'd1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (n_rdy != 3 || n_done != 3) begin
      errors++;
      $display("FAIL b2b_pulses got rdy=%0d done=%0d exp 3 3", n_rdy, n_done);
    end
    checks++;
    if (idle !== 1'b1 || cnt !== m_cnt) begin
      errors++;
      $display("FAIL b2b_end got idle=%b cnt=%0d exp 1 %0d", idle, cnt, m_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    int n_done;
    n_done = 0;
    @(negedge clk);
    a = 32'd77; b = 32'd88; c = 32'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || ret !== 32'd0 || cnt !== 16'd0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL midrst got done=%b ret=%h cnt=%0d idle=%b exp 0 0 0 1",
               done, ret, cnt, idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = '0;
    m_cnt4 = '0;
    last_res = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0 || cnt !== 16'd0 || ret !== 32'd0) begin
      errors++;
      $display("FAIL midrst_after got done_pulses=%0d cnt=%0d ret=%h exp 0 0 0",
               n_done, cnt, ret);
    end
    run_op(32'd4, 32'd6, 32'd5, "postrst");
  endtask

  task automatic test_wrap();
    test_reset();
    for (int i = 1; i <= 16; i++) begin
      run_op($urandom, $urandom, $urandom, "wrap");
      if (i == 15) begin
        checks++;
        if (cnt4 !== 4'd15) begin
          errors++;
          $display("FAIL wrap15 got %0d exp 15", cnt4);
        end
      end
    end
    checks++;
    if (cnt4 !== 4'd0 || cnt !== 16'd16) begin
      errors++;
      $display("FAIL wrap16 got cnt4=%0d cnt=%0d exp 0 16", cnt4, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_hold();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_three_ctrl.md
MAX_THREE_CTRL -- requirements
Module: max_three_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand and result width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 The block SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port ap_start, input, 1 bit: operation request, level-sensitive.
REQ-006 The block SHALL have port ap_ready, output, 1 bit: operands accepted this cycle.
REQ-007 The block SHALL have port ap_done, output, 1 bit: result valid on ap_return, single-cycle pulse.
REQ-008 The block SHALL have port ap_idle, output, 1 bit: controller in IDLE.
REQ-009 The block SHALL have ports a, b, c, each an input of DATA_W bits: unsigned operands.
REQ-010 The block SHALL have port ap_return, output, DATA_W bits: unsigned maximum of the captured a, b, c.
REQ-011 The block SHALL have port ops_cnt, output, CNT_W bits: number of completed operations.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, CMP1, CMP2 and DONE, one cycle per non-IDLE state.
REQ-013 The block SHALL use exactly one DATA_W-bit unsigned greater-than comparator, time-shared between CMP1 and CMP2.
REQ-014 In IDLE with ap_start=1, the block SHALL drive ap_ready=1 combinationally, register a, b and c into a_r, b_r and c_r at the clock edge, and move to CMP1.
REQ-015 In IDLE with ap_start=0, the block SHALL hold all state and keep ap_ready=0.
REQ-016 In CMP1, the block SHALL register m_r <= (a_r > b_r) ? a_r : b_r and move to CMP2.
REQ-017 In CMP2, the block SHALL register res_r <= (m_r > c_r) ? m_r : c_r and move to DONE.
REQ-018 In DONE, the block SHALL drive ap_done=1, increment ops_cnt by 1, and move to IDLE.
REQ-019 ops_cnt SHALL wrap from 2^CNT_W-1 to 0 without saturating and without raising any flag.
REQ-020 Latency SHALL be 3 cycles: ap_start accepted at edge N gives ap_done=1 in the cycle after edge N+2.
REQ-021 Throughput SHALL be one operation per 4 cycles; a start is never accepted in CMP1, CMP2 or DONE.
REQ-022 ap_start held high continuously SHALL start a new operation at each IDLE visit, i.e. every 4th cycle.
REQ-023 Changes on a, b or c after acceptance SHALL NOT affect the result in flight.
REQ-024 ap_return SHALL equal res_r at all times and hold its value from DONE until the next CMP2 update.
REQ-025 Equal operands SHALL give that common value as the result; the choice between tied operands is unobservable.
REQ-026 ap_idle SHALL be 1 exactly when the state is IDLE.
REQ-027 ap_ready SHALL be 1 only in IDLE with ap_start=1.
REQ-028 ap_done SHALL be 1 only in DONE.
REQ-029 All comparisons SHALL be unsigned across the full DATA_W width, with no truncation.

Reset
REQ-030 On ap_rst_n=0, the block SHALL immediately and asynchronously set the state to IDLE and clear a_r, b_r, c_r, m_r, res_r and ops_cnt to 0.
REQ-031 While in reset, the block SHALL drive ap_ready=0, ap_done=0, ap_idle=1 and ap_return=0.
REQ-032 Reset asserted mid-operation SHALL abort the operation: no ap_done pulse and no ops_cnt increment for it.
REQ-033 After ap_rst_n deasserts, the first start SHALL be accepted at the first rising edge with ap_start=1.

Verification
REQ-034 Basic: a=5, b=9, c=3, one-cycle ap_start -> ap_ready high in the start cycle; ap_done 3 cycles later with ap_return=9; ops_cnt=1.
REQ-035 Unsigned/boundary: a=0xFFFFFFFF, b=0, c=0x80000000 -> ap_return=0xFFFFFFFF; then a=b=c=0x1234 -> ap_return=0x1234.
REQ-036 Operand hold: start with a=1, b=2, c=3, then change to a=b=c=100 in the next cycle -> ap_return=3.
REQ-037 Back-to-back: ap_start held high for 12 cycles -> exactly 3 ap_ready pulses and 3 ap_done pulses 4 cycles apart; ap_idle low except in IDLE cycles.
REQ-038 Reset mid-op: assert ap_rst_n=0 during CMP2 -> ap_done stays 0, ap_return=0, ops_cnt unchanged from its pre-op value (0 after reset), ap_idle=1.
REQ-039 Wrap: with CNT_W=4, run 16 operations -> ops_cnt reads 15 after the 15th and 0 after the 16th.
